// File: rtl/spi_cfg_pkg.sv
// Shared definitions for the ADC configuration-port arbiter.
// Holds the arbiter state encoding, frame geometry and the ADC register
// constants also used by the boot sequencer.
package spi_cfg_pkg;

  localparam int unsigned FRAME_W  = 16;
  localparam int unsigned READ_BIT = 15;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StLaunch = 2'b01,
    StWait   = 2'b10,
    StGap    = 2'b11
  } arb_state_e;

  // ADC register map (7-bit addresses); frame = {rd, addr[6:0], data[7:0]}
  localparam logic [6:0] ADC_REG_RESET   = 7'h00;
  localparam logic [6:0] ADC_REG_CLK_CFG = 7'h02;
  localparam logic [6:0] ADC_REG_ID      = 7'h03;

  function automatic logic [FRAME_W-1:0] adc_wr_frame(input logic [6:0] addr,
                                                      input logic [7:0] data);
    return {1'b0, addr, data};
  endfunction

  function automatic logic [FRAME_W-1:0] adc_rd_frame(input logic [6:0] addr);
    return {1'b1, addr, 8'h00};
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req_i   - request vector, one bit per requester
//   last_i  - index of the most recent grant; search starts just after it
//   gnt_o   - one-hot grant (all zero when nothing is requested)
//   valid_o - high when gnt_o holds a grant
module rr_pick #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0] req_i,
  input  logic [1:0]   last_i,
  output logic [N-1:0] gnt_o,
  output logic         valid_o
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  logic [IdxW-1:0] idx;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = '0;
    // Offsets 1..N visit every requester once, the last winner last.
    for (int unsigned k = 1; k <= N; k++) begin
      idx = IdxW'((32'(last_i) + k) % N);
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_cfg_arbiter.sv
// Round-robin arbiter sharing one spi_write serialiser between NREQ requesters.
// One 16-bit frame at a time, idle gap after every frame, completion watchdog.
// Ports:
//   aclk, aresetn        - clock, asynchronous active-low reset
//   req_data/req_valid   - per-requester frame and pending flag (held until accepted)
//   req_ready            - one-hot accept, combinational, only in IDLE
//   req_done             - one-cycle completion/drop pulse to the frame owner
//   eng_data/eng_en      - frame and start pulse to the serialiser
//   eng_done             - serialiser completion pulse (only honoured in WAIT)
//   busy, grant_id       - status: not idle, current/last granted requester
//   err_timeout          - sticky watchdog flag
module spi_cfg_arbiter
  import spi_cfg_pkg::*;
#(
  parameter int unsigned NREQ       = 3,
  parameter int unsigned GAP_CYCLES = 1023,
  parameter int unsigned TIMEOUT    = 4095
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [NREQ*FRAME_W-1:0] req_data,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  output logic [NREQ-1:0]         req_done,
  output logic [FRAME_W-1:0]      eng_data,
  output logic                    eng_en,
  input  logic                    eng_done,
  output logic                    busy,
  output logic [1:0]              grant_id,
  output logic                    err_timeout
);

  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);
  localparam int unsigned ToW  = $clog2(TIMEOUT + 1);
  localparam logic [GapW-1:0] GapLast  = GapW'(GAP_CYCLES - 1);
  localparam logic [ToW-1:0]  ToLast   = ToW'(TIMEOUT - 1);
  localparam logic [1:0]      GrantRst = 2'(NREQ - 1);

  arb_state_e         state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic [FRAME_W-1:0] eng_data_q, eng_data_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic [GapW-1:0]    gap_q, gap_d;
  logic [ToW-1:0]     to_q, to_d;
  logic               err_q, err_d;

  logic [NREQ-1:0]    pick_gnt;
  logic               pick_valid;
  logic [1:0]         pick_idx;
  logic [FRAME_W-1:0] pick_data;
  logic               accept;
  logic [ToW-1:0]     to_inc;
  logic               expire;
  logic [NREQ-1:0]    owner_oh;

  rr_pick #(
    .N(NREQ)
  ) u_rr_pick (
    .req_i  (req_valid),
    .last_i (grant_q),
    .gnt_o  (pick_gnt),
    .valid_o(pick_valid)
  );

  always_comb begin
    pick_idx  = '0;
    pick_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        pick_idx  = 2'(i);
        pick_data = req_data[i*FRAME_W +: FRAME_W];
      end
    end
  end

  assign accept   = (state_q == StIdle) && pick_valid;
  assign owner_oh = NREQ'(1) << grant_q;
  assign to_inc   = (to_q == ToLast) ? to_q : to_q + 1'b1;
  // Last WAIT cycle is the one whose increment reaches TIMEOUT-1, so the flag
  // and the done pulse appear TIMEOUT cycles after eng_en.
  assign expire   = (to_inc == ToLast);

  // State and datapath registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= StIdle;
      grant_q    <= GrantRst;
      eng_data_q <= '0;
      done_q     <= '0;
      gap_q      <= '0;
      to_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      eng_data_q <= eng_data_d;
      done_q     <= done_d;
      gap_q      <= gap_d;
      to_q       <= to_d;
      err_q      <= err_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    eng_data_d = eng_data_q;
    done_d     = '0;
    gap_d      = '0;
    to_d       = '0;
    err_d      = err_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          grant_d = pick_idx;
          if (pick_data[READ_BIT]) begin
            // Reads are not supported on this port: complete the handshake, drop the frame.
            done_d  = pick_gnt;
            state_d = StGap;
          end else begin
            eng_data_d = pick_data;
            state_d    = StLaunch;
          end
        end
      end
      StLaunch: state_d = StWait;
      StWait: begin
        to_d = to_inc;
        if (eng_done || expire) begin
          done_d  = owner_oh;
          state_d = StGap;
          if (!eng_done) err_d = 1'b1;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    // Gated by aresetn so no accept is offered while reset is held.
    req_ready   = (state_q == StIdle && aresetn) ? pick_gnt : '0;
    req_done    = done_q;
    eng_data    = eng_data_q;
    eng_en      = (state_q == StLaunch);
    busy        = (state_q != StIdle);
    grant_id    = grant_q;
    err_timeout = err_q;
  end

endmodule

// File: tb/tb_spi_cfg_arbiter.sv
module tb_spi_cfg_arbiter;
  import spi_cfg_pkg::*;

  localparam int NREQ = 3;
  localparam int GAP  = 8;
  localparam int TMO  = 16;

  logic                 aclk = 1'b0;
  logic                 aresetn;
  logic [NREQ*16-1:0]   req_data;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ-1:0]      req_done;
  logic [15:0]          eng_data;
  logic                 eng_en;
  logic                 eng_done;
  logic                 busy;
  logic [1:0]           grant_id;
  logic                 err_timeout;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Transaction-level reference state
  int          ptr;
  bit [NREQ-1:0] pend;
  logic [15:0] pdata [NREQ];
  bit          exp_err;
  logic [15:0] exp_data;

  spi_cfg_arbiter #(
    .NREQ      (NREQ),
    .GAP_CYCLES(GAP),
    .TIMEOUT   (TMO)
  ) dut (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .req_data   (req_data),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_done   (req_done),
    .eng_data   (eng_data),
    .eng_en     (eng_en),
    .eng_done   (eng_done),
    .busy       (busy),
    .grant_id   (grant_id),
    .err_timeout(err_timeout)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin rule: first pending requester after the last winner.
  function automatic int pick();
    for (int k = 1; k <= NREQ; k++) begin
      if (pend[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    end
    return 0;
  endfunction

  task automatic drive(input bit junk);
    req_valid = pend;
    for (int i = 0; i < NREQ; i++) begin
      if (pend[i]) begin
        req_data[16*i +: 16] = pdata[i];
      end else if (junk) begin
        req_valid[i]         = 1'($urandom_range(0, 1));
        req_data[16*i +: 16] = 16'($urandom);
      end else begin
        req_data[16*i +: 16] = 16'h0;
      end
    end
  endtask

  task automatic new_frame(input int i, input bit allow_read);
    pend[i]  = 1'b1;
    pdata[i] = {allow_read && ($urandom_range(0, 3) == 0), 15'($urandom)};
  endtask

  task automatic refill();
    for (int i = 0; i < NREQ; i++) begin
      if (!pend[i] && $urandom_range(0, 1) == 1) new_frame(i, 1'b1);
    end
    if (pend == '0) new_frame(int'($urandom_range(0, NREQ - 1)), 1'b1);
  endtask

  // One full frame from an IDLE cycle to the next IDLE cycle.
  // d: WAIT cycle index at which eng_done pulses; d >= TMO-1 means never.
  task automatic run_txn(input int d, input bit spurious);
    int w;
    int r;
    bit rd;
    bit to;
    w  = pick();
    rd = pdata[w][READ_BIT];
    drive(1'b0);
    eng_done = 1'b0;
    @(negedge aclk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(req_done), 32'd0);
    chk("ready", 32'(req_ready), 32'(oh(w)));
    chk("idle_eng_en", 32'(eng_en), 32'd0);
    @(posedge aclk); #1;
    pend[w] = 1'b0;
    ptr     = w;
    if (!rd) exp_data = pdata[w];
    // r: cycles from handshake to the req_done cycle
    if (rd) begin
      r  = 1;
      to = 1'b0;
    end else begin
      r  = 1 + ((d + 2 < TMO) ? d + 2 : TMO);
      to = (d >= TMO - 1);
    end
    for (int c = 1; c < r; c++) begin
      drive(1'b1);
      eng_done = !rd && (c == d + 2);
      @(negedge aclk);
      chk("eng_en", 32'(eng_en), 32'(!rd && c == 1));
      chk("early_done", 32'(req_done), 32'd0);
      chk("busy_ready", 32'(req_ready), 32'd0);
      chk("busy", 32'(busy), 32'd1);
      chk("err_before", 32'(err_timeout), 32'(exp_err));
      if (c == 1) chk("eng_data", 32'(eng_data), 32'(exp_data));
      @(posedge aclk); #1;
    end
    exp_err = exp_err | to;
    drive(1'b1);
    eng_done = spurious && ($urandom_range(0, 1) == 1);
    @(negedge aclk);
    chk("req_done", 32'(req_done), 32'(oh(w)));
    chk("err", 32'(err_timeout), 32'(exp_err));
    chk("grant_id", 32'(grant_id), 32'(w));
    chk("eng_data_hold", 32'(eng_data), 32'(exp_data));
    chk("gap_eng_en", 32'(eng_en), 32'd0);
    @(posedge aclk); #1;
    for (int g = 1; g < GAP; g++) begin
      drive(1'b1);
      eng_done = spurious && ($urandom_range(0, 1) == 1);
      @(negedge aclk);
      chk("gap_done", 32'(req_done), 32'd0);
      chk("gap_ready", 32'(req_ready), 32'd0);
      chk("gap_busy", 32'(busy), 32'd1);
      @(posedge aclk); #1;
    end
    eng_done = 1'b0;
  endtask

  task automatic idle_spurious();
    req_valid = '0;
    eng_done  = 1'b1;
    @(negedge aclk);
    chk("sp_busy", 32'(busy), 32'd0);
    chk("sp_ready", 32'(req_ready), 32'd0);
    @(posedge aclk); #1;
    eng_done = 1'b0;
    @(negedge aclk);
    chk("sp_done", 32'(req_done), 32'd0);
    chk("sp_busy2", 32'(busy), 32'd0);
    @(posedge aclk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_eng_en"}, 32'(eng_en), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_done"}, 32'(req_done), 32'd0);
    chk({tag, "_eng_data"}, 32'(eng_data), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'(NREQ - 1));
    chk({tag, "_err"}, 32'(err_timeout), 32'd0);
  endtask

  initial begin
    aresetn   = 1'b1;
    req_valid = '0;
    req_data  = '0;
    eng_done  = 1'b0;
    ptr       = NREQ - 1;
    pend      = '0;
    exp_err   = 1'b0;
    exp_data  = 16'h0;
    for (int i = 0; i < NREQ; i++) pdata[i] = 16'h0;

    #2 aresetn = 1'b0;
    #2 chk_reset_outputs("rst");
    repeat (2) @(posedge aclk);
    #3 aresetn = 1'b1;

    // Single write from requester 0
    pend     = 3'b001;
    pdata[0] = adc_wr_frame(ADC_REG_CLK_CFG, 8'h01);
    run_txn(3, 1'b0);

    // eng_done while idle is ignored
    idle_spurious();

    // Read frame is dropped but still completes
    pend     = 3'b010;
    pdata[1] = adc_rd_frame(ADC_REG_ID);
    run_txn(0, 1'b0);

    // Park the pointer on 2, then all three contend: order 0,1,2,0
    pend     = 3'b100;
    pdata[2] = 16'h0A55;
    run_txn(5, 1'b0);
    pend     = 3'b111;
    pdata[0] = adc_wr_frame(ADC_REG_RESET, 8'h11);
    pdata[1] = 16'h0122;
    pdata[2] = 16'h0233;
    for (int n = 0; n < 4; n++) begin
      run_txn(n, 1'b0);
      pend[ptr]  = 1'b1;
      pdata[ptr] = 16'(16'h0300 + n);
    end

    // Watchdog: done on the expiry cycle succeeds, then a real expiry
    run_txn(TMO - 2, 1'b0);
    run_txn(TMO + 3, 1'b0);
    run_txn(4, 1'b0);

    // Random traffic
    repeat (30) begin
      refill();
      run_txn(int'($urandom_range(0, TMO)), 1'b1);
    end

    // Reset in the middle of WAIT
    pend     = 3'b001;
    pdata[0] = adc_wr_frame(ADC_REG_RESET, 8'h5A);
    run_txn(2, 1'b0);
    pend     = 3'b110;
    pdata[1] = 16'h1234;
    pdata[2] = 16'h2345;
    drive(1'b0);
    @(negedge aclk);
    chk("pre_rst_ready", 32'(req_ready), 32'(oh(1)));
    @(posedge aclk); #1;
    pend[1] = 1'b0;
    drive(1'b0);
    @(posedge aclk); #1;
    #2 aresetn = 1'b0;
    #1 chk_reset_outputs("mid_rst");
    ptr      = NREQ - 1;
    exp_err  = 1'b0;
    exp_data = 16'h0;
    repeat (3) begin
      @(negedge aclk);
      chk("rst_hold_done", 32'(req_done), 32'd0);
      chk("rst_hold_ready", 32'(req_ready), 32'd0);
    end
    @(posedge aclk);
    #3 aresetn = 1'b1;
    pend[0]  = 1'b1;
    pdata[0] = 16'h0777;
    run_txn(1, 1'b0);
    run_txn(1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
